// File: rtl/int_div_iter.sv
// Iterative unsigned restoring divider with val/rdy request and response ports.
// One quotient bit per cycle; control FSM and shift/subtract datapath kept separate.

module int_div_iter_ctrl #(
  parameter int nbits = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_val,
  input  logic       resp_rdy,
  input  logic       cnt_last,
  output logic       req_rdy,
  output logic       resp_val,
  output logic       load,
  output logic       step,
  output logic [1:0] state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_next;

  // Handshake rule for both ports: a transfer happens on a rising edge where
  // val and rdy are both high; rdy never depends on the peer's val.
  assign req_rdy  = reset && (state == IDLE);
  assign resp_val = reset && (state == DONE);
  assign load     = req_val && req_rdy;
  assign step     = (state == CALC);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CALC;
      CALC:    if (cnt_last) state_next = DONE;
      DONE:    if (resp_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

endmodule

module int_div_iter_dpath #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [nbits-1:0] dividend,
  input  logic [nbits-1:0] divisor,
  output logic [nbits-1:0] quotient,
  output logic [nbits-1:0] remainder,
  output logic             cnt_last
);

  localparam int CW = $clog2(nbits) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(nbits - 1);

  logic [nbits-1:0] q_reg;
  logic [nbits-1:0] r_reg;
  logic [nbits-1:0] d_reg;
  logic [CW-1:0]    cnt_reg;
  logic [nbits:0]   t;
  logic [nbits:0]   diff;
  logic             neg;

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign t    = {r_reg, q_reg[nbits-1]};
  assign diff = t - {1'b0, d_reg};
  assign neg  = diff[nbits];

  assign quotient  = q_reg;
  assign remainder = r_reg;
  assign cnt_last  = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg   <= '0;
      r_reg   <= '0;
      d_reg   <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      q_reg   <= dividend;
      r_reg   <= '0;
      d_reg   <= divisor;
      cnt_reg <= '0;
    end else if (step) begin
      q_reg   <= {q_reg[nbits-2:0], ~neg};
      r_reg   <= neg ? t[nbits-1:0] : diff[nbits-1:0];
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

module int_div_iter #(
  parameter int nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*nbits-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [2*nbits-1:0] resp_msg
);

  logic             load;
  logic             step;
  logic             cnt_last;
  logic [1:0]       state;
  logic [nbits-1:0] quotient;
  logic [nbits-1:0] remainder;

  int_div_iter_ctrl #(.nbits(nbits)) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .resp_rdy (resp_rdy),
    .cnt_last (cnt_last),
    .req_rdy  (req_rdy),
    .resp_val (resp_val),
    .load     (load),
    .step     (step),
    .state    (state)
  );

  int_div_iter_dpath #(.nbits(nbits)) u_dpath (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .dividend  (req_msg[2*nbits-1:nbits]),
    .divisor   (req_msg[nbits-1:0]),
    .quotient  (quotient),
    .remainder (remainder),
    .cnt_last  (cnt_last)
  );

  // Message is forced to zero while reset is held, even before the first edge.
  assign resp_msg = reset ? {quotient, remainder} : '0;

endmodule

// File: tb/tb_int_div_iter.sv
// Directed-vector bench for int_div_iter: latency, extremes, divide by zero,
// backpressure, ignored requests and reset during a calculation.

module tb_int_div_iter;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [63:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [63:0] resp_msg;

  int n_checks = 0;
  int n_errs   = 0;

  int_div_iter dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive at a falling edge once req_rdy is high; fire on the next rising edge.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_rdy_wait", {63'd0, req_rdy}, 64'd1);
    req_val = 1'b1;
    req_msg = {a, b};
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    req_msg = '0;
  endtask

  // Called at the first falling edge after the fire; returns cycles to resp_val.
  task automatic wait_resp(output int cycles);
    cycles = 1;
    while (!resp_val && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    int lat;
    resp_rdy = 1'b1;
    send_req(a, b);
    wait_resp(lat);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_msg"}, resp_msg, {eq, er});
    @(negedge clk);
    check({tag, "_val_after"}, {63'd0, resp_val}, 64'd0);
    check({tag, "_rdy_after"}, {63'd0, req_rdy}, 64'd1);
  endtask

  initial begin
    int lat;
    int stray;
    reset    = 1'b0;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
    check("rst_resp_val", {63'd0, resp_val}, 64'd0);
    check("rst_resp_msg", resp_msg, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", {63'd0, req_rdy}, 64'd1);

    // Basic and extreme operands
    run_div("basic", 32'd100, 32'd7, 32'd14, 32'd2);
    run_div("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_div("small_by_max", 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5);
    run_div("zero_num", 32'd0, 32'd9, 32'd0, 32'd0);
    run_div("div_zero", 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);

    // Backpressure: response held for five cycles
    resp_rdy = 1'b0;
    send_req(32'd1000, 32'd3);
    wait_resp(lat);
    check("bp_latency", 64'(lat), 64'd33);
    for (int i = 0; i < 5; i++) begin
      check("bp_msg", resp_msg, {32'd333, 32'd1});
      check("bp_val", {63'd0, resp_val}, 64'd1);
      check("bp_req_rdy", {63'd0, req_rdy}, 64'd0);
      @(negedge clk);
    end
    check("bp_msg_last", resp_msg, {32'd333, 32'd1});
    resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_fired", {63'd0, resp_val}, 64'd0);
    check("bp_idle", {63'd0, req_rdy}, 64'd1);

    // Ignored request pulse during CALC
    send_req(32'd100, 32'd7);
    repeat (4) @(negedge clk);
    req_val = 1'b1;
    req_msg = {32'd50, 32'd5};
    @(negedge clk);
    req_val = 1'b0;
    req_msg = '0;
    wait_resp(lat);
    check("ign_latency", 64'(lat + 5), 64'd33);
    check("ign_msg", resp_msg, {32'd14, 32'd2});
    @(negedge clk);
    check("ign_idle", {63'd0, req_rdy}, 64'd1);
    run_div("fresh", 32'd50, 32'd5, 32'd10, 32'd0);

    // Reset mid-calculation
    send_req(32'd77, 32'd4);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_val", {63'd0, resp_val}, 64'd0);
    check("mid_rst_rdy", {63'd0, req_rdy}, 64'd0);
    check("mid_rst_msg", resp_msg, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_idle", {63'd0, req_rdy}, 64'd1);
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_val) stray++;
      @(negedge clk);
    end
    check("no_stale_resp", 64'(stray), 64'd0);
    run_div("after_rst", 32'd77, 32'd4, 32'd19, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
